imem_load_ctrl: RTL and testbench

- Shares the single-port program ROM between instruction fetch and a byte-stream loader, e.g. the UART bootloader.
- In RUN mode, fetch owns the ROM address.
- In LOAD mode, incoming bytes are packed little-endian into 32-bit words and written sequentially from word 0. The CPU is held in reset so it restarts at PC 0.
- Sits between the fetch stage, the UART receiver and the prgrom block RAM.

---
 rtl/imem_load_ctrl_pkg.sv | 15 +
 rtl/imem_load_ctrl_if.sv | 23 ++
 rtl/imem_byte_packer.sv | 69 ++++++
 rtl/imem_load_ctrl.sv | 119 +++++++++++
 tb/tb_imem_load_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the program-ROM load controller: FSM states and ROM geometry.
package imem_load_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_LOAD,
        ST_FLUSH,
        ST_FINISH
    } state_e;

    localparam int ROM_ADDR_W = 14;
    localparam int ROM_DEPTH  = 16384;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Byte-stream, fetch-address and prgrom port bundle.
// master = load controller, slave = UART/fetch/ROM side.
interface imem_load_ctrl_if import imem_load_ctrl_pkg::*; #(
    parameter int ADDR_W = ROM_ADDR_W
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_we;
    logic [31:0]       rom_wdata;

    modport master (
        input  byte_valid, byte_data, fetch_addr,
        output byte_ready, rom_addr, rom_we, rom_wdata
    );

    modport slave (
        output byte_valid, byte_data, fetch_addr,
        input  byte_ready, rom_addr, rom_we, rom_wdata
    );
endinterface

// File: rtl/imem_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words.
// A completed word is staged with a pending flag until the parent writes it.
module imem_byte_packer import imem_load_ctrl_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    input  logic        write_i,
    output logic [1:0]  byte_cnt_o,
    output logic        pend_o,
    output logic [31:0] staged_o,
    output logic [31:0] partial_o
);
    logic [31:0] asm_q, asm_d;
    logic [31:0] staged_q, staged_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            asm_q    <= '0;
            staged_q <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            asm_q    <= asm_d;
            staged_q <= staged_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        asm_d    = asm_q;
        staged_d = staged_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        if (write_i)
            pend_d = 1'b0;
        if (clear_i) begin
            asm_d  = '0;
            cnt_d  = '0;
            pend_d = 1'b0;
        end else if (accept_i) begin
            asm_d[8*cnt_q +: 8] = byte_i;
            cnt_d = cnt_q + 2'd1;
            // The completing byte bypasses asm_q so the staged word is whole at this edge.
            if (cnt_q == 2'd3) begin
                staged_d = {byte_i, asm_q[23:0]};
                pend_d   = 1'b1;
            end
        end
    end

    // Lanes at or above byte_cnt may hold bytes from an earlier word.
    always_comb begin
        unique case (cnt_q)
            2'd0: partial_o = '0;
            2'd1: partial_o = {24'h0, asm_q[7:0]};
            2'd2: partial_o = {16'h0, asm_q[15:0]};
            default: partial_o = {8'h0, asm_q[23:0]};
        endcase
    end

    assign byte_cnt_o = cnt_q;
    assign pend_o     = pend_q;
    assign staged_o   = staged_q;
endmodule

// File: rtl/imem_load_ctrl.sv
// Arbitrates the single-port program ROM between instruction fetch and a byte loader.
// The CPU is held in reset for the whole load so it restarts at PC 0.
module imem_load_ctrl import imem_load_ctrl_pkg::*; #(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DEPTH  = ROM_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_req,
    imem_load_ctrl_if.master bus,
    output logic             cpu_rst_n,
    output logic             stall,
    output logic             busy,
    output logic             load_done,
    output logic [ADDR_W:0]  word_count
);
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] LIMIT    = (ADDR_W+1)'(DEPTH);

    state_e          state_q, state_d;
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;

    logic        pk_clear, pk_write, pend, accept;
    logic [1:0]  byte_cnt;
    logic [31:0] staged, partial;

    imem_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (pk_clear),
        .accept_i   (accept),
        .byte_i     (bus.byte_data),
        .write_i    (pk_write),
        .byte_cnt_o (byte_cnt),
        .pend_o     (pend),
        .staged_o   (staged),
        .partial_o  (partial)
    );

    assign accept = bus.byte_valid && bus.byte_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        bus.rom_addr   = bus.fetch_addr;
        bus.rom_we     = 1'b0;
        bus.rom_wdata  = staged;
        bus.byte_ready = 1'b0;
        cpu_rst_n      = 1'b0;
        stall          = 1'b1;
        busy           = 1'b1;
        load_done      = 1'b0;
        pk_clear       = 1'b0;
        pk_write       = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                cpu_rst_n = 1'b1;
                stall     = 1'b0;
                busy      = 1'b0;
                if (load_req)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                wr_ptr_d = '0;
                pk_clear = 1'b1;
                state_d  = ST_LOAD;
            end
            ST_LOAD: begin
                bus.rom_addr   = wr_ptr_q[ADDR_W-1:0];
                bus.byte_ready = !(pend && wr_ptr_q == LAST_PTR);
                if (pend) begin
                    bus.rom_we = 1'b1;
                    pk_write   = 1'b1;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                end
                if (pend && wr_ptr_q == LAST_PTR)
                    state_d = ST_FINISH;
                else if (!load_req)
                    state_d = (byte_cnt != 2'd0) ? ST_FLUSH : ST_FINISH;
            end
            ST_FLUSH: begin
                bus.rom_addr = wr_ptr_q[ADDR_W-1:0];
                if (pend) begin
                    bus.rom_we = 1'b1;
                    pk_write   = 1'b1;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                end else begin
                    // A word completed while entering FLUSH leaves no partial; skip the empty write.
                    if (byte_cnt != 2'd0 && wr_ptr_q < LIMIT) begin
                        bus.rom_we    = 1'b1;
                        bus.rom_wdata = partial;
                        wr_ptr_d      = wr_ptr_q + 1'b1;
                    end
                    pk_clear = 1'b1;
                    state_d  = ST_FINISH;
                end
            end
            ST_FINISH: begin
                bus.rom_addr = wr_ptr_q[ADDR_W-1:0];
                load_done    = 1'b1;
                state_d      = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign word_count = wr_ptr_q;
endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: full-depth instance plus a DEPTH=4 instance.
module tb_imem_load_ctrl;
    import imem_load_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic load_req = 1'b0;
    logic load_req4 = 1'b0;
    logic cpu_rst_n, stall, busy, load_done;
    logic cpu_rst_n4, stall4, busy4, load_done4;
    logic [ROM_ADDR_W:0] word_count, word_count4;

    imem_load_ctrl_if #(.ADDR_W(ROM_ADDR_W)) bus ();
    imem_load_ctrl_if #(.ADDR_W(ROM_ADDR_W)) bus4 ();

    imem_load_ctrl #(.ADDR_W(ROM_ADDR_W), .DEPTH(ROM_DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_req   (load_req),
        .bus        (bus),
        .cpu_rst_n  (cpu_rst_n),
        .stall      (stall),
        .busy       (busy),
        .load_done  (load_done),
        .word_count (word_count)
    );

    imem_load_ctrl #(.ADDR_W(ROM_ADDR_W), .DEPTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .load_req   (load_req4),
        .bus        (bus4),
        .cpu_rst_n  (cpu_rst_n4),
        .stall      (stall4),
        .busy       (busy4),
        .load_done  (load_done4),
        .word_count (word_count4)
    );

    always #5 clk = ~clk;

    // ROM models: capture writes the way prgrom would
    logic [31:0] rom  [0:63];
    logic [31:0] rom4 [0:3];
    int nwr = 0, nwr4 = 0, bad4 = 0;
    logic [ROM_ADDR_W-1:0] last_addr = '0;

    always @(posedge clk) begin
        if (bus.rom_we) begin
            rom[bus.rom_addr[5:0]] <= bus.rom_wdata;
            last_addr <= bus.rom_addr;
            nwr <= nwr + 1;
        end
    end

    always @(posedge clk) begin
        if (bus4.rom_we) begin
            if (bus4.rom_addr < 4) rom4[bus4.rom_addr[1:0]] <= bus4.rom_wdata;
            else bad4 <= bad4 + 1;
            nwr4 <= nwr4 + 1;
        end
    end

    int nvec = 0;
    int nerr = 0;
    int ready_low = 0;
    logic [7:0] v2 [8];
    logic [7:0] v3 [6];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        #1;
        if (!bus.byte_ready) ready_low++;
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic idle_load();
        bus.byte_valid = 1'b0;
        #1;
        if (!bus.byte_ready) ready_low++;
        tick();
    endtask

    initial begin
        int n0, acc, ndone, done_at, wc_at_done;
        logic rdy16;
        v2 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        v3 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        bus.byte_valid  = 1'b0;
        bus.byte_data   = '0;
        bus.fetch_addr  = 14'h005;
        bus4.byte_valid = 1'b0;
        bus4.byte_data  = '0;
        bus4.fetch_addr = '0;

        // reset, then RUN: fetch owns the ROM
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_rom_addr", bus.rom_addr, 64'h5);
        chk("rst_stall", stall, 0);
        chk("rst_cpu_rst_n", cpu_rst_n, 1);
        chk("rst_rom_we", bus.rom_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_byte_ready", bus.byte_ready, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_word_count", word_count, 0);

        // two full words back-to-back
        n0 = nwr;
        ready_low = 0;
        load_req = 1'b1;
        tick();
        #1;
        chk("drain_stall", stall, 1);
        chk("drain_cpu_rst_n", cpu_rst_n, 0);
        chk("drain_byte_ready", bus.byte_ready, 0);
        chk("drain_rom_addr", bus.rom_addr, 64'h5);
        chk("drain_busy", busy, 1);
        tick();
        foreach (v2[i]) send(v2[i]);
        load_req = 1'b0;
        #1;
        chk("w1_rom_we", bus.rom_we, 1);
        chk("w1_rom_addr", bus.rom_addr, 1);
        chk("w1_rom_wdata", bus.rom_wdata, 64'h00100093);
        tick();
        #1;
        chk("fin_load_done", load_done, 1);
        chk("fin_word_count", word_count, 2);
        chk("fin_cpu_rst_n", cpu_rst_n, 0);
        chk("fin_stall", stall, 1);
        tick();
        #1;
        chk("run_load_done", load_done, 0);
        chk("run_cpu_rst_n", cpu_rst_n, 1);
        chk("run_busy", busy, 0);
        chk("full_rom0", rom[0], 64'h00000013);
        chk("full_rom1", rom[1], 64'h00100093);
        chk("full_nwr", nwr - n0, 2);
        chk("full_ready_low", ready_low, 0);

        // six bytes then drop: FLUSH writes a zero-padded partial word
        n0 = nwr;
        load_req = 1'b1;
        tick();
        tick();
        #1;
        chk("drain_clears_wc", word_count, 0);
        foreach (v3[i]) send(v3[i]);
        load_req = 1'b0;
        tick();
        #1;
        chk("flush_rom_we", bus.rom_we, 1);
        chk("flush_rom_addr", bus.rom_addr, 1);
        chk("flush_rom_wdata", bus.rom_wdata, 64'h00002211);
        chk("flush_byte_ready", bus.byte_ready, 0);
        tick();
        #1;
        chk("flush_fin_done", load_done, 1);
        chk("flush_fin_wc", word_count, 2);
        tick();
        #1;
        chk("part_rom0", rom[0], 64'hDDCCBBAA);
        chk("part_rom1", rom[1], 64'h00002211);
        chk("part_nwr", nwr - n0, 2);

        // gapped bytes: same image as the back-to-back load
        n0 = nwr;
        ready_low = 0;
        load_req = 1'b1;
        tick();
        tick();
        foreach (v2[i]) begin
            send(v2[i]);
            idle_load();
            idle_load();
        end
        load_req = 1'b0;
        tick();
        #1;
        chk("gap_done", load_done, 1);
        chk("gap_wc", word_count, 2);
        tick();
        #1;
        chk("gap_ready_low", ready_low, 0);
        chk("gap_rom0", rom[0], 64'h00000013);
        chk("gap_rom1", rom[1], 64'h00100093);
        chk("gap_nwr", nwr - n0, 2);

        // DEPTH=4: 20 bytes offered, load ends on its own after word 3
        n0 = nwr4;
        acc = 0;
        ndone = 0;
        done_at = -1;
        wc_at_done = -1;
        rdy16 = 1'b1;
        load_req4 = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            bus4.byte_valid = 1'b1;
            bus4.byte_data  = 8'(i + 1);
            #1;
            if (bus4.byte_ready) acc++;
            if (i == 16) rdy16 = bus4.byte_ready;
            if (load_done4) begin
                ndone++;
                done_at = i;
                wc_at_done = int'(word_count4);
                load_req4 = 1'b0;
            end
            tick();
        end
        bus4.byte_valid = 1'b0;
        #1;
        chk("d4_accepted", acc, 16);
        chk("d4_writes", nwr4 - n0, 4);
        chk("d4_bad_addr", bad4, 0);
        chk("d4_done_pulses", ndone, 1);
        chk("d4_done_cycle", done_at, 17);
        chk("d4_ready_last", rdy16, 0);
        chk("d4_word_count", wc_at_done, 4);
        chk("d4_rom0", rom4[0], 64'h04030201);
        chk("d4_rom3", rom4[3], 64'h100F0E0D);
        chk("d4_busy_end", busy4, 0);

        // reset in the middle of word 3
        n0 = nwr;
        load_req = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 14; i++) send(8'(8'h21 + i));
        rst = 1'b0;
        load_req = 1'b0;
        tick();
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_rom_we", bus.rom_we, 0);
        chk("mrst_cpu_rst_n", cpu_rst_n, 1);
        chk("mrst_word_count", word_count, 0);
        chk("mrst_stall", stall, 0);
        chk("mrst_rom_addr", bus.rom_addr, 64'h5);
        rst = 1'b1;
        tick();
        #1;
        chk("mrst_rom0", rom[0], 64'h24232221);
        chk("mrst_rom1", rom[1], 64'h28272625);
        chk("mrst_rom2", rom[2], 64'h2C2B2A29);
        chk("mrst_nwr", nwr - n0, 3);
        chk("mrst_last_addr", last_addr, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
